// File: rtl/mac_requant_out.sv
// Requantizes a 48b MAC accumulator word to int8 lanes (round, shift, saturate).
// Optional REQUANT_RELU_EN clamps negative lane results to zero after saturation.
module mac_requant_out #(
    parameter int ACC_W   = 48,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 split,
    input  logic [ACC_W-1:0]     acc_in,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 acc_valid,
    output logic                 acc_ready,
    output logic [2*OUT_W-1:0]   q_out,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic [CNT_W-1:0]     sat_cnt,
    input  logic                 clr_sat
);

    function automatic logic signed [32:0] rnd_shift(
        input logic signed [32:0] x,
        input logic [4:0]         s
    );
        logic signed [32:0] half;
        half = (s == 5'd0) ? '0 : $signed(33'd1 << (s - 5'd1));
        return (x + half) >>> s;
    endfunction

    // Bit 8 flags a saturation event; bits 7:0 are the lane result.
    function automatic logic [8:0] sat8(input logic signed [32:0] r);
        logic [8:0] res;
        if (r > 33'sd127) begin
            res = {1'b1, 8'h7F};
        end else if (r < -33'sd128) begin
            res = {1'b1, 8'h80};
        end else begin
            res = {1'b0, r[7:0]};
        end
`ifdef REQUANT_RELU_EN
        if (res[7]) begin
            res[7:0] = 8'h00;
        end
`endif
        return res;
    endfunction

    logic                rdy_q;
    logic                s1_v_q, s1_v_d;
    logic signed [32:0]  s1_r1_q, s1_r1_d;
    logic signed [32:0]  s1_r0_q, s1_r0_d;
    logic                q_valid_q, q_valid_d;
    logic [15:0]         q_out_q, q_out_d;
    logic [CNT_W-1:0]    sat_cnt_q, sat_cnt_d;

    logic                s1_adv, s2_adv, accept, load2;
    logic [4:0]          s_eff;
    logic signed [32:0]  x1, x0;
    logic [8:0]          l1, l0;
    logic [1:0]          ev;
    logic [CNT_W:0]      cnt_sum;

    assign s2_adv    = !q_valid_q || q_ready;
    assign s1_adv    = !s1_v_q || s2_adv;
    assign acc_ready = rdy_q && s1_adv;
    assign accept    = acc_valid && acc_ready;
    assign load2     = s1_v_q && s2_adv;

    always_comb begin
        x1    = {{9{acc_in[47]}}, acc_in[47:24]};
        x0    = split ? {{9{acc_in[23]}}, acc_in[23:0]}
                      : {acc_in[31], acc_in[31:0]};
        s_eff = (split && shift > 5'd23) ? 5'd23 : shift;
        s1_v_d  = s1_adv ? accept : s1_v_q;
        s1_r1_d = s1_r1_q;
        s1_r0_d = s1_r0_q;
        if (accept) begin
            // A zeroed lane1 in non-split mode yields 0 and no event.
            s1_r1_d = split ? rnd_shift(x1, s_eff) : '0;
            s1_r0_d = rnd_shift(x0, s_eff);
        end
    end

    always_comb begin
        l1        = sat8(s1_r1_q);
        l0        = sat8(s1_r0_q);
        ev        = {1'b0, l1[8]} + {1'b0, l0[8]};
        cnt_sum   = {1'b0, sat_cnt_q} + (CNT_W+1)'(ev);
        q_valid_d = s2_adv ? s1_v_q : q_valid_q;
        q_out_d   = load2 ? {l1[7:0], l0[7:0]} : q_out_q;
        sat_cnt_d = sat_cnt_q;
        if (clr_sat) begin
            sat_cnt_d = '0;
        end else if (load2) begin
            sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_r1_q   <= '0;
            s1_r0_q   <= '0;
            q_valid_q <= 1'b0;
            q_out_q   <= '0;
            sat_cnt_q <= '0;
        end else begin
            rdy_q     <= 1'b1;
            s1_v_q    <= s1_v_d;
            s1_r1_q   <= s1_r1_d;
            s1_r0_q   <= s1_r0_d;
            q_valid_q <= q_valid_d;
            q_out_q   <= q_out_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign q_out   = q_out_q;
    assign q_valid = q_valid_q;
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_mac_requant_out.sv
// Scoreboard bench for mac_requant_out against an arithmetic reference model.
// Define REQUANT_RELU_EN for both DUT and bench to check the ReLU build.
module tb_mac_requant_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        split = 1'b0;
    logic [47:0] acc_in = '0;
    logic [4:0]  shift = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [15:0] q_out;
    logic        q_valid;
    logic        q_ready = 1'b1;
    logic [15:0] sat_cnt;
    logic        clr_sat = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [15:0] exp_q[$];
    logic        hold_chk = 1'b0;
    logic [15:0] held = '0;

    mac_requant_out dut (
        .clk(clk), .rst_n(rst_n), .split(split), .acc_in(acc_in),
        .shift(shift), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .q_out(q_out), .q_valid(q_valid), .q_ready(q_ready),
        .sat_cnt(sat_cnt), .clr_sat(clr_sat)
    );

    always #5 clk = ~clk;

    function automatic int lane(input longint x, input int s, output int ev);
        longint num, d, r;
        num = x + ((s > 0) ? (longint'(1) << (s - 1)) : 0);
        d = longint'(1) << s;
        r = num / d;
        if ((num % d != 0) && (num < 0)) r = r - 1;
        ev = 0;
        if (r > 127) begin r = 127; ev = 1; end
        if (r < -128) begin r = -128; ev = 1; end
`ifdef REQUANT_RELU_EN
        if (r < 0) r = 0;
`endif
        return int'(r);
    endfunction

    function automatic logic [17:0] model(input logic sp, input logic [47:0] a,
                                          input logic [4:0] sh);
        int l, s, e1, e0, q1, q0;
        logic [7:0] b1, b0;
        l = sp ? 24 : 32;
        s = (int'(sh) > l - 1) ? l - 1 : int'(sh);
        if (sp) begin
            q1 = lane(longint'($signed(a[47:24])), s, e1);
            q0 = lane(longint'($signed(a[23:0])), s, e0);
        end else begin
            q1 = 0;
            e1 = 0;
            q0 = lane(longint'($signed(a[31:0])), s, e0);
        end
        b1 = q1[7:0];
        b0 = q0[7:0];
        return {2'(e1 + e0), (sp ? b1 : 8'h00), b0};
    endfunction

    task automatic push(input logic sp, input logic [47:0] a, input logic [4:0] sh);
        logic [17:0] m;
        m = model(sp, a, sh);
        exp_q.push_back(m[15:0]);
        exp_cnt = exp_cnt + int'(m[17:16]);
        if (exp_cnt > 65535) exp_cnt = 65535;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called and returns at posedge+1; holds the beat until accepted.
    task automatic send(input logic sp, input logic [47:0] a, input logic [4:0] sh);
        bit done;
        done = 0;
        acc_valid = 1'b1;
        split = sp;
        acc_in = a;
        shift = sh;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (acc_ready) begin
                push(sp, a, sh);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        acc_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        q_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !q_valid) done = 1;
        end
        check("drain", 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", 32'(q_valid), 32'd1);
                check("hold_data", 32'(q_out), 32'(held));
            end
            hold_chk = q_valid && !q_ready;
            held = q_out;
            if (q_valid && q_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(q_out), 32'hDEAD_BEEF);
                end else begin
                    check("q_out", 32'(q_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [47:0] SATB = {24'h7FFFFF, 24'h800000};

    initial begin
        logic [47:0] a;
        int sm;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_q_out", 32'(q_out), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_acc_ready", 32'(acc_ready), 32'd1);

        send(1'b0, 48'd1000, 5'd4);
        send(1'b0, {16'hABCD, 32'hFFFFFC18}, 5'd4);
        send(1'b1, {24'd5000, 24'hFFFFEC}, 5'd3);
        send(1'b1, {24'h000014, 24'hFFFFEC}, 5'd2);
        send(1'b1, {24'h800000, 24'h000003}, 5'd31);
        send(1'b0, 48'h0000_7FFF_FFFF, 5'd31);
        drain();
        check("sat_cnt_dir", 32'(sat_cnt), 32'(exp_cnt));

        q_ready = 1'b0;
        send(1'b0, 48'd300, 5'd1);
        send(1'b1, {24'd77, 24'hFFFF00}, 5'd0);
        acc_valid = 1'b1;
        split = 1'b0;
        acc_in = 48'd5;
        shift = 5'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(acc_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        q_ready = 1'b1;
        send(1'b0, 48'd5, 5'd1);
        drain();

        for (int i = 0; i < 600; i++) begin
            q_ready = ($urandom_range(0, 3) != 0);
            acc_valid = $urandom_range(0, 1) == 1;
            split = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) begin
                a = {$urandom(), $urandom()};
            end else begin
                sm = int'($urandom_range(0, 8191)) - 4096;
                a = {sm[23:0], sm[23:0]};
                if (!split) a[31:0] = sm;
            end
            acc_in = a;
            shift = $urandom_range(0, 1) ? 5'($urandom_range(0, 31))
                                         : 5'($urandom_range(0, 6));
            @(negedge clk);
            if (acc_valid && acc_ready) push(split, acc_in, shift);
            @(posedge clk);
            #1;
        end
        acc_valid = 1'b0;
        drain();
        check("sat_cnt_rand", 32'(sat_cnt), 32'(exp_cnt));

        q_ready = 1'b0;
        send(1'b1, SATB, 5'd0);
        send(1'b1, SATB, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q_valid", 32'(q_valid), 32'd0);
        check("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        q_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(q_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(acc_ready), 32'd1);

        for (int i = 0; i < 32767; i++) send(1'b1, SATB, 5'd0);
        drain();
        check("sat_cnt_fffe", 32'(sat_cnt), 32'h0000FFFE);
        send(1'b1, SATB, 5'd0);
        drain();
        check("sat_cnt_sticky", 32'(sat_cnt), 32'(exp_cnt));
        send(1'b1, SATB, 5'd0);
        drain();
        check("sat_cnt_stay", 32'(sat_cnt), 32'h0000FFFF);

        send(1'b1, SATB, 5'd0);
        clr_sat = 1'b1;
        @(posedge clk);
        #1;
        clr_sat = 1'b0;
        exp_cnt = 0;
        drain();
        check("sat_cnt_clr", 32'(sat_cnt), 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
